// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared definitions for the I2C transaction arbiter:
//   - state_e      : sequencer FSM states
//   - ERR_*        : rsp_err encodings returned to requesters
//   - SLAVE_W/BYTE_W : transaction field widths
//   - cnt_width()  : counter width able to hold 0..n-1, never below one bit
package i2c_pkg;

  localparam int SLAVE_W = 7;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic int cnt_width(input int n_values);
    return (n_values <= 2) ? 1 : $clog2(n_values);
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if
// Bundles the requester side (req_*/rsp_*), the core transaction port
// (core_*) and the status outputs (busy, owner) of the arbiter.
//   slave  : arbiter view (drives req_ready, rsp_*, core_* outputs, status)
//   master : environment view (requesters plus the i2c core)
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import i2c_pkg::*;

  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [SLAVE_W*NUM_REQ-1:0] req_slave_addr;
  logic [BYTE_W*NUM_REQ-1:0]  req_reg_addr;
  logic [BYTE_W*NUM_REQ-1:0]  req_wdata;
  logic [NUM_REQ-1:0]         req_rw;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [BYTE_W-1:0]          rsp_rdata;
  logic [1:0]                 rsp_err;
  logic                       core_start;
  logic [SLAVE_W-1:0]         core_slave_addr;
  logic [BYTE_W-1:0]          core_reg_addr;
  logic [BYTE_W-1:0]          core_write_data;
  logic                       core_rw;
  logic [BYTE_W-1:0]          core_read_data;
  logic                       core_done;
  logic                       core_ack_error;
  logic                       busy;
  logic [OW-1:0]              owner;

  modport slave (
    input  req_valid, req_slave_addr, req_reg_addr, req_wdata, req_rw,
    input  core_read_data, core_done, core_ack_error,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output core_start, core_slave_addr, core_reg_addr, core_write_data, core_rw,
    output busy, owner
  );

  modport master (
    output req_valid, req_slave_addr, req_reg_addr, req_wdata, req_rw,
    output core_read_data, core_done, core_ack_error,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  core_start, core_slave_addr, core_reg_addr, core_write_data, core_rw,
    input  busy, owner
  );

endinterface

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts at last+1 and wraps,
// so the most recent owner has the lowest priority.
//   req       : request vector
//   last      : index of the last granted requester
//   grant     : one-hot grant (all zero when nothing requests)
//   grant_idx : index of the granted requester
//   grant_vld : any requester granted
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_vld
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;
  logic             hit;

  // Walk candidates last+1 .. last+NUM_REQ (mod NUM_REQ); first request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    hit       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      hit  = !grant_vld && req[cand];
      if (hit) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_vld   = 1'b1;
      end else begin
        grant_idx   = grant_idx;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter
// Shares one i2c_master_core among NUM_REQ requesters. One transaction is
// accepted per grant, issued to the core, retried after NACK (with an idle
// gap), bounded by a timeout, and answered with a one-cycle response.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : i2c_txn_arbiter_if.slave (requests, responses, core port,
//                busy, owner)
// Cycle shape: grant (req_ready) in T while still IDLE, ISSUE/core_start in
// T+1, WAIT from T+2; core_done in D gives RESP/rsp_valid in D+1, IDLE in D+2.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_RETRY   = 2,
  parameter int RETRY_GAP   = 64,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  i2c_txn_arbiter_if.slave  bus
);
  localparam int OW    = $clog2(NUM_REQ);
  localparam int RTY_W = cnt_width(MAX_RETRY + 1);
  localparam int TMO_W = cnt_width(TIMEOUT_CYC);
  localparam int GAP_W = cnt_width(RETRY_GAP);

  localparam logic [RTY_W-1:0]   RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_SAT  = '1;
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(RETRY_GAP - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [BYTE_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_err_q, rsp_err_d;
  logic               core_start_q, core_start_d;
  logic [SLAVE_W-1:0] slave_q, slave_d;
  logic [BYTE_W-1:0]  reg_q, reg_d;
  logic [BYTE_W-1:0]  wdata_q, wdata_d;
  logic               rw_q, rw_d;
  logic               busy_q, busy_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [OW-1:0]      arb_idx;
  logic               arb_vld;
  logic [SLAVE_W-1:0] sel_slave;
  logic [BYTE_W-1:0]  sel_reg;
  logic [BYTE_W-1:0]  sel_wdata;
  logic               sel_rw;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (bus.req_valid),
    .last      (owner_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // AND-OR mux of the winner's request fields, indexed by the one-hot grant.
  always_comb begin
    sel_slave = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    sel_rw    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_slave = sel_slave | (bus.req_slave_addr[i*SLAVE_W +: SLAVE_W] & {SLAVE_W{arb_grant[i]}});
      sel_reg   = sel_reg   | (bus.req_reg_addr[i*BYTE_W +: BYTE_W]    & {BYTE_W{arb_grant[i]}});
      sel_wdata = sel_wdata | (bus.req_wdata[i*BYTE_W +: BYTE_W]       & {BYTE_W{arb_grant[i]}});
      sel_rw    = sel_rw    | (bus.req_rw[i] & arb_grant[i]);
    end
  end

  // Sequencer next-state logic; pulse outputs are set on entry to their state.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_err_d    = ERR_OK;
    core_start_d = 1'b0;
    slave_d      = slave_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    rw_d         = rw_q;
    owner_d      = owner_q;
    rty_d        = rty_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    case (state_q)
      ST_IDLE: begin
        // A grant issued last cycle moves to ISSUE; the requester has
        // dropped (or is dropping) req_valid so it must not be re-arbitrated.
        if (req_ready_q != '0) begin
          state_d      = ST_ISSUE;
          core_start_d = 1'b1;
        end else if (arb_vld) begin
          req_ready_d = arb_grant;
          owner_d     = arb_idx;
          slave_d     = sel_slave;
          reg_d       = sel_reg;
          wdata_d     = sel_wdata;
          rw_d        = sel_rw;
          rty_d       = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_d = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + TMO_W'(1);
        // core_done is tested before the timeout so a coincident completion wins.
        if (bus.core_done) begin
          if (!bus.core_ack_error) begin
            rsp_valid_d = ONE_HOT0 << owner_q;
            rsp_rdata_d = rw_q ? bus.core_read_data : '0;
            rsp_err_d   = ERR_OK;
            state_d     = ST_RESP;
          end else if (rty_q < RTY_MAX) begin
            rty_d   = rty_q + RTY_W'(1);
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            rsp_valid_d = ONE_HOT0 << owner_q;
            rsp_err_d   = ERR_NACK;
            state_d     = ST_RESP;
          end
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d = ONE_HOT0 << owner_q;
          rsp_err_d   = ERR_TIMEOUT;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d      = ST_ISSUE;
          core_start_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= ERR_OK;
      core_start_q <= 1'b0;
      slave_q      <= '0;
      reg_q        <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
      owner_q      <= OW'(NUM_REQ - 1);
      rty_q        <= '0;
      tmo_q        <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      core_start_q <= core_start_d;
      slave_q      <= slave_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      rty_q        <= rty_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.core_start      = core_start_q;
  assign bus.core_slave_addr = slave_q;
  assign bus.core_reg_addr   = reg_q;
  assign bus.core_write_data = wdata_q;
  assign bus.core_rw         = rw_q;
  assign bus.busy            = busy_q;
  assign bus.owner           = owner_q;

endmodule
